// File: rtl/hazard_sequencer.sv
// Hazard controller for a 5-stage pipeline: EX operand forwarding selects, load-use stalls,
// taken-branch flushes and whole-pipeline freezes while data memory is not ready.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_write_reg,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [1:0]       forward_A,
    output logic [1:0]       forward_B,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a_s, fwd_b_s;
    logic       load_use_s;
    logic       freeze_s, advance_s;
    logic       pc_write_s, if_id_write_s, if_id_flush_s, id_ex_write_s;
    logic       id_ex_bubble_s, ex_mem_write_s, mem_wb_bubble_s, mem_timeout_s;

    // EX/MEM result is younger than MEM/WB, so it wins when both match; $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        logic [1:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and load-use detection
    always_comb begin
        fwd_a_s    = fwd_sel(ex_rs, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg);
        fwd_b_s    = fwd_sel(ex_rt, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg);
        load_use_s = ex_mem_read && (ex_write_reg != 5'd0) &&
                     ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
    end

    // Sequencer: memory-wait FSM plus branch/load-use pipeline controls
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        freeze_s        = 1'b0;
        advance_s       = 1'b0;
        mem_timeout_s   = 1'b0;
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_write_s   = 1'b1;
        id_ex_bubble_s  = 1'b0;
        ex_mem_write_s  = 1'b1;
        mem_wb_bubble_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_s   = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    advance_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready && (wait_cnt_q < TIMEOUT_V)) begin
                    freeze_s   = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    advance_s     = 1'b1;
                    mem_timeout_s = !mem_ready;
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (freeze_s) begin
            pc_write_s      = 1'b0;
            if_id_write_s   = 1'b0;
            id_ex_write_s   = 1'b0;
            ex_mem_write_s  = 1'b0;
            mem_wb_bubble_s = 1'b1;
        end else if (advance_s && branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use match there is irrelevant.
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (advance_s && load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_write_s = 1'b1;
        end

        if (!pc_write_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, wait counter and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset overrides the stage controls so the pipeline holds safe NOPs
    always_comb begin
        if (rst) begin
            forward_A     = 2'b00;
            forward_B     = 2'b00;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_write   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_bubble = 1'b1;
            mem_timeout   = 1'b0;
        end else begin
            forward_A     = fwd_a_s;
            forward_B     = fwd_b_s;
            pc_write      = pc_write_s;
            if_id_write   = if_id_write_s;
            if_id_flush   = if_id_flush_s;
            id_ex_write   = id_ex_write_s;
            id_ex_bubble  = id_ex_bubble_s;
            ex_mem_write  = ex_mem_write_s;
            mem_wb_bubble = mem_wb_bubble_s;
            mem_timeout   = mem_timeout_s;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized and directed bench for hazard_sequencer against a rule-level reference model.
module tb_hazard_sequencer;

    localparam int T      = 4;
    localparam int CNT_W  = 4;
    localparam int CNTMAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rs = 5'd0, ex_rt = 5'd0;
    logic [4:0] ex_write_reg = 5'd0, mem_write_reg = 5'd0, wb_write_reg = 5'd0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic [1:0] forward_A, forward_B;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic       ex_mem_write, mem_wb_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state: consecutive memory-wait cycles so far (0 = not waiting)
    int m_wait = 0;
    int m_cnt  = 0;
    int e_fa, e_fb, e_pc, e_ifw, e_fl, e_idw, e_bub, e_exw, e_mwb, e_to, e_freeze;
    int last_pc, last_to, last_fa;

    hazard_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .forward_A(forward_A), .forward_B(forward_B),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd(input logic [4:0] src);
        if (mem_reg_write && mem_write_reg != 0 && mem_write_reg == src) return 2;
        if (wb_reg_write && wb_write_reg != 0 && wb_write_reg == src) return 1;
        return 0;
    endfunction

    task automatic model_outputs();
        bit lu, advance;
        e_fa = fwd(ex_rs); e_fb = fwd(ex_rt);
        e_pc = 1; e_ifw = 1; e_fl = 0; e_idw = 1; e_bub = 0; e_exw = 1; e_mwb = 0; e_to = 0;
        e_freeze = 0;
        if (m_wait == 0) e_freeze = (mem_req && !mem_ready) ? 1 : 0;
        else             e_freeze = (!mem_ready && m_wait < T) ? 1 : 0;
        advance = (e_freeze == 0);
        if (m_wait != 0 && advance && !mem_ready) e_to = 1;
        lu = ex_mem_read && ex_write_reg != 0 &&
             (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
        if (e_freeze != 0) begin
            e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_mwb = 1;
        end else if (branch_taken) begin
            e_fl = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
    endtask

    // one clock: check outputs mid-cycle, then advance the model at the edge
    task automatic cycle();
        @(negedge clk);
        model_outputs();
        chk("fwdA", forward_A, e_fa);     chk("fwdB", forward_B, e_fb);
        chk("pc_write", pc_write, e_pc);  chk("if_id_write", if_id_write, e_ifw);
        chk("if_id_flush", if_id_flush, e_fl); chk("id_ex_write", id_ex_write, e_idw);
        chk("id_ex_bubble", id_ex_bubble, e_bub); chk("ex_mem_write", ex_mem_write, e_exw);
        chk("mem_wb_bubble", mem_wb_bubble, e_mwb); chk("mem_timeout", mem_timeout, e_to);
        chk("stall_cnt", stall_cnt, m_cnt);
        last_pc = pc_write; last_to = mem_timeout; last_fa = forward_A;
        @(posedge clk);
        if (e_freeze != 0) m_wait = m_wait + 1; else m_wait = 0;
        if (e_pc == 0 && m_cnt < CNTMAX) m_cnt++;
        #1;
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg} = '0;
        {id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready} = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fa"}, forward_A, 0);   chk({tag, "_pc"}, pc_write, 0);
        chk({tag, "_ifw"}, if_id_write, 0); chk({tag, "_bub"}, id_ex_bubble, 1);
        chk({tag, "_mwb"}, mem_wb_bubble, 1); chk({tag, "_idw"}, id_ex_write, 1);
        chk({tag, "_exw"}, ex_mem_write, 1); chk({tag, "_to"}, mem_timeout, 0);
        chk({tag, "_cnt"}, stall_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        // inputs that would otherwise forward/stall, to show reset overrides them
        mem_reg_write = 1'b1; mem_write_reg = 5'd3; ex_rs = 5'd3;
        #1;
        check_reset_outputs("rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b0; m_wait = 0; m_cnt = 0;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic rand_inputs();
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
        ex_write_reg = 5'($urandom_range(0, 3)); mem_write_reg = 5'($urandom_range(0, 3));
        wb_write_reg = 5'($urandom_range(0, 3));
        id_uses_rt = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
        mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
        branch_taken = ($urandom_range(0, 5) == 0);
        mem_req = ($urandom_range(0, 2) == 0);
        mem_ready = ($urandom_range(0, 1) == 0);
    endtask

    initial begin
        do_reset();

        // forwarding priority and $0 exclusion
        ex_rs = 5'd3; mem_reg_write = 1'b1; mem_write_reg = 5'd3; wb_reg_write = 1'b1; wb_write_reg = 5'd3;
        cycle(); chk("t1_fa_mem", last_fa, 2);
        mem_write_reg = 5'd0; wb_reg_write = 1'b0; ex_rs = 5'd0;
        cycle(); chk("t1_fa_zero", last_fa, 0);
        clear_inputs();

        // load-use: one bubble
        ex_mem_read = 1'b1; ex_write_reg = 5'd5; id_rs = 5'd5;
        cycle(); chk("t2_stall", last_pc, 0);
        ex_mem_read = 1'b0;
        cycle(); chk("t2_go", last_pc, 1); chk("t2_cnt", stall_cnt, 1);

        // branch beats load-use
        ex_mem_read = 1'b1; branch_taken = 1'b1;
        cycle(); chk("t3_pc", last_pc, 1); chk("t3_cnt", stall_cnt, 1);
        clear_inputs();
        do_reset();

        // memory wait released by ready
        mem_req = 1'b1;
        repeat (3) cycle();
        mem_ready = 1'b1;
        cycle(); chk("t4_rel", last_pc, 1); chk("t4_to", last_to, 0); chk("t4_cnt", stall_cnt, 3);
        clear_inputs();
        cycle();

        // memory wait forced release
        mem_req = 1'b1;
        repeat (T) begin cycle(); chk("t5_frz", last_pc, 0); end
        cycle(); chk("t5_to", last_to, 1); chk("t5_rel", last_pc, 1);
        mem_req = 1'b0;
        cycle(); chk("t5_to_gone", last_to, 0);
        clear_inputs();

        // async reset in second MEM_WAIT cycle
        mem_req = 1'b1;
        cycle(); cycle();
        rst = 1'b1; #1;
        check_reset_outputs("t6");
        @(negedge clk); rst = 1'b0; m_wait = 0; m_cnt = 0;
        clear_inputs();
        cycle(); chk("t6_run", last_pc, 1);

        // randomized traffic, long enough to saturate the counter
        repeat (400) begin
            rand_inputs();
            cycle();
        end
        chk("sat_cnt", stall_cnt, CNTMAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
